// File: rtl/bcd_disp_pkg.sv
// Shared types, constants and elaboration-time helpers for the BCD scan driver.
package bcd_disp_pkg;

  // Nibble value the downstream 7-segment decoder renders as "all segments off".
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // Largest value representable with ndig decimal digits (10^ndig - 1).
  function automatic longint max_dec(input int ndig);
    longint p;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input longint value);
    int w;
    w = 1;
    while ((longint'(1) << w) < value) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction: every BCD nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_stage
  import bcd_disp_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [4*NDIG-1:0] bcd_out
);

  // Per-nibble conditional +3, purely combinational.
  always_comb begin
    bcd_out = bcd_in;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (one bit per clock) feeding a time-multiplexed
// digit scanner that drives one shared 7-segment decoder plus active-low
// digit enables. Leading zeros are blanked with BLANK_CODE.
module bcd_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int BIN_W    = 10,
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [3:0]       digit_bcd,
  output logic [NDIG-1:0]  an_n
);

  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = clog2(BIN_W);
  localparam int PRE_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NDIG);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0] LAST_PRE  = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NDIG - 1);
  localparam longint           MAX_VAL   = max_dec(NDIG);
  localparam logic [BCD_W-1:0] ALL_NINES = {NDIG{4'h9}};

  // Conversion state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic               overflow_q, overflow_d;
  logic [BCD_W-1:0]   disp_q, disp_d;

  // Scan state
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NDIG-1:0]    an_n_q, an_n_d;
  logic [3:0]         digit_q, digit_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic               tick;
  logic [IDX_W-1:0]   idx_nxt;
  logic               upper_zero;

  bcd_add3_stage #(
    .NDIG (NDIG)
  ) u_add3 (
    .bcd_in  (bcd_q),
    .bcd_out (bcd_adj)
  );

  assign busy      = (state_q == CONV);
  assign overflow  = overflow_q;
  assign digit_bcd = digit_q;
  assign an_n      = an_n_q;
  assign tick      = (presc_q == LAST_PRE);

  // FSM next state and shift-add-3 datapath; completion publishes the result.
  always_comb begin
    // NOTE: every signal driven here is given a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    ovf_cap_d  = ovf_cap_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d   = CONV;
          shift_d   = bin_in;
          bcd_d     = '0;
          bit_cnt_d = '0;
          ovf_cap_d = (64'(bin_in) > MAX_VAL);
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        bit_cnt_d        = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d    = IDLE;
          disp_d     = ovf_cap_q ? ALL_NINES : bcd_d;
          overflow_d = ovf_cap_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the display register is datapath, but it is reset too so the
    // display shows 0 after reset instead of a stale or undefined value.
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_cap_q  <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      ovf_cap_q  <= ovf_cap_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
    end
  end

  // Prescaler, digit rotation and leading-zero blanking; outputs move only on tick.
  always_comb begin
    presc_d    = (presc_q == LAST_PRE) ? '0 : presc_q + PRE_W'(1);
    idx_d      = idx_q;
    an_n_d     = an_n_q;
    digit_d    = digit_q;
    idx_nxt    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    upper_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if ((IDX_W'(i) >= idx_nxt) && (disp_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    if (tick) begin
      idx_d   = idx_nxt;
      an_n_d  = ~(NDIG'(1) << idx_nxt);
      digit_d = ((BLANK_LZ != 0) && (idx_nxt != '0) && upper_zero)
                ? BLANK_CODE : disp_q[4*idx_nxt +: 4];
    end
  end

  // Scan registers; enable and nibble update on the same edge so they never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= LAST_IDX;
      an_n_q  <= '1;
      digit_q <= BLANK_CODE;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_n_q  <= an_n_d;
      digit_q <= digit_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench: two DUTs (NDIG=4 and NDIG=3) share one clock. Stimulus
// pushes the expected display value for each accepted load; a monitor pops
// it when busy falls and checks every scan slot against a decimal model.
module tb_bcd_scan_driver;

  localparam int BIN_W    = 10;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Decimal digit idx of value, blanked when it is a leading zero above digit 0.
  function automatic logic [3:0] model_digit(input int value, input int idx);
    int scaled = value / pow10(idx);
    if (idx > 0 && scaled == 0) return 4'hF;
    return 4'(scaled % 10);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int ND    = (g == 0) ? 4 : 3;
    localparam int DIR_A = (g == 0) ? 937 : 1000;
    localparam int DIR_B = (g == 0) ? 1005 : 42;
    localparam int SCAN_WAIT = BIN_W + ND * SCAN_DIV * 2 + 2;

    typedef struct {
      int value;
      bit ovf;
      int load_cyc;
    } exp_t;

    exp_t             exp_q[$];
    logic             rst_n;
    logic             load;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             overflow;
    logic [3:0]       digit_bcd;
    logic [ND-1:0]    an_n;
    bit               done = 1'b0;
    int               last_acc = -1000;
    int               max_val = pow10(ND) - 1;

    bcd_scan_driver #(
      .BIN_W    (BIN_W),
      .NDIG     (ND),
      .SCAN_DIV (SCAN_DIV),
      .BLANK_LZ (1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_in    (bin_in),
      .load      (load),
      .busy      (busy),
      .overflow  (overflow),
      .digit_bcd (digit_bcd),
      .an_n      (an_n)
    );

    function automatic string nm(input string s);
      return $sformatf("n%0d_%s", ND, s);
    endfunction

    task automatic idle(input int n);
      repeat (n) @(posedge clk);
    endtask

    // One-cycle load pulse; the model decides acceptance from its own timeline.
    task automatic do_load(input int v);
      int edge_no;
      @(posedge clk);
      #1;
      load    = 1'b1;
      bin_in  = BIN_W'(v);
      edge_no = cyc + 1;
      if (edge_no > last_acc + BIN_W) begin
        exp_q.push_back('{value: (v > max_val) ? max_val : v,
                          ovf: (v > max_val), load_cyc: edge_no});
        last_acc = edge_no;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
      check(nm({tag, "_busy"}), busy, 0);
      check(nm({tag, "_overflow"}), overflow, 0);
      check(nm({tag, "_an_n"}), an_n, {ND{1'b1}});
      check(nm({tag, "_digit"}), digit_bcd, 4'hF);
    endtask

    initial begin : stimulus
      rst_n  = 1'b0;
      load   = 1'b0;
      bin_in = '0;
      idle(2);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      idle(ND * SCAN_DIV * 2 + 2);
      do_load(DIR_A);
      idle(SCAN_WAIT);
      do_load(DIR_B);
      idle(SCAN_WAIT);
      do_load(512);
      idle(1);
      do_load(512 + 7);
      idle(SCAN_WAIT);
      repeat (12) begin
        do_load(int'($urandom_range(0, 1023)));
        idle(int'($urandom_range(0, BIN_W + 6)));
      end
      idle(SCAN_WAIT);
      do_load(999);
      idle(4);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      last_acc = -1000;
      idle(2);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      idle(ND * SCAN_DIV * 2 + 4);
      check(nm("queue_empty"), exp_q.size(), 0);
      done = 1'b1;
    end

    int            model_value = 0;
    bit            model_ovf = 1'b0;
    int            exp_idx = ND - 1;
    logic [ND-1:0] prev_an_n = '1;
    logic [ND-1:0] want_an;
    bit            prev_busy = 1'b0;
    int            busy_cnt = 0;
    int            last_tick_cyc = 0;
    exp_t          e;

    always @(negedge clk) begin : monitor
      if (rst_n !== 1'b1) begin
        exp_q.delete();
        model_value   = 0;
        model_ovf     = 1'b0;
        exp_idx       = ND - 1;
        prev_an_n     = '1;
        prev_busy     = 1'b0;
        busy_cnt      = 0;
        last_tick_cyc = cyc;
      end else begin
        // Scan slot: checked against the display value from before this edge.
        if (an_n !== prev_an_n) begin
          exp_idx = (exp_idx == ND - 1) ? 0 : exp_idx + 1;
          want_an = ~(ND'(1) << exp_idx);
          check(nm("tick_interval"), cyc - last_tick_cyc, SCAN_DIV);
          check(nm("an_n"), an_n, want_an);
          check(nm($sformatf("digit%0d", exp_idx)), digit_bcd,
                model_digit(model_value, exp_idx));
          last_tick_cyc = cyc;
          prev_an_n     = an_n;
        end else if (cyc - last_tick_cyc > SCAN_DIV) begin
          check(nm("tick_missing"), cyc - last_tick_cyc, SCAN_DIV);
          last_tick_cyc = cyc;
        end
        // Conversion completion.
        if (busy === 1'b1) busy_cnt++;
        if (prev_busy && busy !== 1'b1) begin
          if (exp_q.size() == 0) begin
            check(nm("unexpected_done"), exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check(nm("latency"), cyc - e.load_cyc, BIN_W);
            check(nm("busy_len"), busy_cnt, BIN_W);
            model_value = e.value;
            model_ovf   = e.ovf;
          end
          busy_cnt = 0;
        end else if (exp_q.size() > 0 && cyc - exp_q[0].load_cyc > BIN_W + 3) begin
          check(nm("done_timeout"), cyc - exp_q[0].load_cyc, BIN_W);
          void'(exp_q.pop_front());
          busy_cnt = 0;
        end
        prev_busy = (busy === 1'b1);
        check(nm("overflow"), overflow, model_ovf);
      end
    end
  end

  initial begin : summary
    wait (g_inst[0].done && g_inst[1].done);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "time limit reached");
  end

endmodule
